// File: rtl/miriscv_lsu_seq_if.sv
// miriscv load/store sequencer port bundle.
// Core-side request/response plus data-memory bus.
interface miriscv_lsu_seq_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  lsu_req_i;
  logic                  lsu_we_i;
  logic [2:0]            lsu_size_i;
  logic [ADDR_WIDTH-1:0] lsu_addr_i;
  logic [31:0]           lsu_wdata_i;
  logic [31:0]           lsu_rdata_o;
  logic                  lsu_done_o;
  logic                  lsu_err_o;
  logic                  lsu_stall_o;
  logic                  data_req_o;
  logic                  data_gnt_i;
  logic                  data_rvalid_i;
  logic [31:0]           data_rdata_i;
  logic [ADDR_WIDTH-1:0] data_addr_o;
  logic                  data_we_o;
  logic [3:0]            data_be_o;
  logic [31:0]           data_wdata_o;

  modport slave (
    input  lsu_req_i,
    input  lsu_we_i,
    input  lsu_size_i,
    input  lsu_addr_i,
    input  lsu_wdata_i,
    input  data_gnt_i,
    input  data_rvalid_i,
    input  data_rdata_i,
    output lsu_rdata_o,
    output lsu_done_o,
    output lsu_err_o,
    output lsu_stall_o,
    output data_req_o,
    output data_addr_o,
    output data_we_o,
    output data_be_o,
    output data_wdata_o
  );

  modport master (
    output lsu_req_i,
    output lsu_we_i,
    output lsu_size_i,
    output lsu_addr_i,
    output lsu_wdata_i,
    output data_gnt_i,
    output data_rvalid_i,
    output data_rdata_i,
    input  lsu_rdata_o,
    input  lsu_done_o,
    input  lsu_err_o,
    input  lsu_stall_o,
    input  data_req_o,
    input  data_addr_o,
    input  data_we_o,
    input  data_be_o,
    input  data_wdata_o
  );
endinterface

// File: rtl/miriscv_lsu_seq.sv
// miriscv load/store sequencer: aligns, enables bytes,
// runs req/gnt/rvalid and extends loaded data.
module miriscv_lsu_seq #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  miriscv_lsu_seq_if.slave lsu
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DONE,
    ERR
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [1:0]  off;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        bad_op;
  logic        accept;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [2:0]            size_q;
  logic [1:0]            off_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;
  logic        bus_req;
  logic        done;
  logic        err;
  logic        load_cap;

  assign off    = lsu.lsu_addr_i[1:0];
  assign accept = (state_q == IDLE) & lsu.lsu_req_i;

  // Decode access width from funct3.
  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    unique case (lsu.lsu_size_i)
      3'b000, 3'b100: is_b = 1'b1;
      3'b001, 3'b101: is_h = 1'b1;
      3'b010:         is_w = 1'b1;
      default:        ;
    endcase
  end

  assign bad_op = ~(is_b | is_h | is_w)
                | (is_h & off[0])
                | (is_w & (off != 2'b00));

  // Byte lanes and replicated store data for the request.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = lsu.lsu_wdata_i;
    unique case (1'b1)
      is_b: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{lsu.lsu_wdata_i[7:0]}};
      end
      is_h: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{lsu.lsu_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    bus_req = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lsu.lsu_req_i) begin
          state_d = bad_op ? ERR : REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (lsu.data_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (lsu.data_rvalid_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_sel = lsu.data_rdata_i[{off_q, 3'b000} +: 8];
  assign half_sel = lsu.data_rdata_i[{off_q[1], 4'b0000} +: 16];

  // Sign or zero extend the selected lane.
  always_comb begin
    ext = lsu.data_rdata_i;
    unique case (size_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext = {24'h0, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext = {16'h0, half_sel};
      default: ext = lsu.data_rdata_i;
    endcase
  end

  assign load_cap = (state_q == RESP)
                  & lsu.data_rvalid_i
                  & ~we_q;

  // Latch the request; bus fields only for legal ops.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else if (accept) begin
      size_q <= lsu.lsu_size_i;
      off_q  <= off;
      if (!bad_op) begin
        addr_q  <= {lsu.lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
        we_q    <= lsu.lsu_we_i;
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
    end
  end

  // Load result, held until the next load completes.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rdata_q <= 32'h0;
    end else if (load_cap) begin
      rdata_q <= ext;
    end
  end

  assign lsu.data_req_o   = bus_req;
  assign lsu.data_addr_o  = addr_q;
  assign lsu.data_we_o    = we_q;
  assign lsu.data_be_o    = be_q;
  assign lsu.data_wdata_o = wdata_q;
  assign lsu.lsu_rdata_o  = rdata_q;
  assign lsu.lsu_done_o   = done;
  assign lsu.lsu_err_o    = err;
  assign lsu.lsu_stall_o  = lsu.lsu_req_i & ~done;

endmodule
